// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with fill count, almost-full/empty thresholds,
// synchronous flush and sticky overflow/underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
`default_nettype none

module sync_fifo_flags #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_THRESH  = (2**ADDR_WIDTH) - 2,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int                DEPTH      = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] c_AF_CNT   = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] c_AE_CNT   = (ADDR_WIDTH+1)'(AE_THRESH);
   localparam logic [ADDR_WIDTH:0] c_ONE      = (ADDR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_ov_set;
   logic                  w_uf_set;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [ADDR_WIDTH-1:0] w_rd_addr;

   assign w_full    = (r_count == c_FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
   assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

   // flush swallows this cycle's requests, so they neither move data nor raise errors
   assign w_wr_acc  = wr_en && !w_full  && !flush;
   assign w_rd_acc  = rd_en && !w_empty && !flush;
   assign w_ov_set  = wr_en &&  w_full  && !flush;
   assign w_uf_set  = rd_en &&  w_empty && !flush;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[w_wr_addr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + c_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + c_ONE;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + c_ONE;
            2'b01:   r_count <= r_count - c_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // a set event in the same cycle takes priority over clr_err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ov_set) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end
         if (w_uf_set) begin
            r_underflow <= 1'b1;
         end else if (clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = w_empty ? '0 : r_mem[w_rd_addr];
   assign rd_valid = !w_empty;
`else
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_rd_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out <= '0;
         r_rd_valid <= 1'b0;
      end else if (flush) begin
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_data_out <= r_mem[w_rd_addr];
         end
      end
   end

   assign data_out = r_data_out;
   assign rd_valid = r_rd_valid;
`endif

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= c_AF_CNT);
   assign almost_empty = (r_count <= c_AE_CNT);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: table-driven directed checks of sync_fifo_flags (DEPTH=8, AF=6, AE=1), standard mode.
`default_nettype none

module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       rd_en = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] data_out;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_fail   = 0;

   sync_fifo_flags #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (3),
      .AF_THRESH  (6),
      .AE_THRESH  (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .data_out     (data_out),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         wr;
      bit         rd;
      bit         fl;
      bit         clr;
      logic [7:0] din;
      int         cnt;
      bit         ov;
      bit         uf;
      bit         rv;
      logic [7:0] dout;
   } vec_t;

   vec_t vq[$];

   task automatic add(input bit wr, input bit rd, input bit fl, input bit clr,
                      input logic [7:0] din, input int cnt,
                      input bit ov, input bit uf, input bit rv, input logic [7:0] dout);
      vec_t v;
      v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.din = din;
      v.cnt = cnt; v.ov = ov; v.uf = uf; v.rv = rv; v.dout = dout;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int cnt, input bit ov, input bit uf,
                          input bit rv, input logic [7:0] dout);
      chk({tag, ".count"},        32'(count),        32'(cnt));
      chk({tag, ".full"},         32'(full),         32'(cnt == 8));
      chk({tag, ".empty"},        32'(empty),        32'(cnt == 0));
      chk({tag, ".almost_full"},  32'(almost_full),  32'(cnt >= 6));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= 1));
      chk({tag, ".overflow"},     32'(overflow),     32'(ov));
      chk({tag, ".underflow"},    32'(underflow),    32'(uf));
      chk({tag, ".rd_valid"},     32'(rd_valid),     32'(rv));
      chk({tag, ".data_out"},     32'(data_out),     32'(dout));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ed;
      ed = 8'h00;

      // Test 1: fill 0x11..0x88, flags track count
      for (int k = 1; k <= 8; k++) add(1, 0, 0, 0, 8'(17 * k), k, 0, 0, 0, ed);
      // Test 2: write while full is dropped, then drain in order
      add(1, 0, 0, 0, 8'h99, 8, 1, 0, 0, ed);
      for (int j = 1; j <= 8; j++) begin
         ed = 8'(17 * j);
         add(0, 1, 0, 0, 8'h00, 8 - j, 1, 0, 1, ed);
      end
      // Test 3: underflow, set beats clr_err, then clr_err alone
      add(0, 1, 0, 0, 8'h00, 0, 1, 1, 0, ed);
      add(0, 1, 0, 1, 8'h00, 0, 0, 1, 0, ed);
      add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, ed);
      // Test 4: fill 4, 20 simultaneous wr/rd, then drain
      for (int i = 1; i <= 4; i++) add(1, 0, 0, 0, 8'(i), i, 0, 0, 0, ed);
      for (int i = 0; i < 20; i++) begin
         ed = (i < 4) ? 8'(i + 1) : 8'(160 + i - 4);
         add(1, 1, 0, 0, 8'(160 + i), 4, 0, 0, 1, ed);
      end
      for (int i = 16; i < 20; i++) begin
         ed = 8'(160 + i);
         add(0, 1, 0, 0, 8'h00, 19 - i, 0, 0, 1, ed);
      end
      // Test 5: fill 5, pop one, flush with wr/rd asserted, then 0x42 round trip
      for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 8'(80 + i), i + 1, 0, 0, 0, ed);
      ed = 8'h50;
      add(0, 1, 0, 0, 8'h00, 4, 0, 0, 1, ed);
      add(1, 1, 1, 0, 8'hEE, 0, 0, 0, 0, ed);
      add(1, 0, 0, 0, 8'h42, 1, 0, 0, 0, ed);
      ed = 8'h42;
      add(0, 1, 0, 0, 8'h00, 0, 0, 0, 1, ed);
      // flush while full with wr_en high must not raise overflow
      for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 8'(96 + i), i + 1, 0, 0, 0, ed);
      add(1, 0, 1, 0, 8'hEE, 0, 0, 0, 0, ed);
      // set underflow, then fill 3 ahead of the mid-burst reset
      add(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, ed);
      for (int i = 1; i <= 3; i++) add(1, 0, 0, 0, 8'(48 + i), i, 0, 1, 0, ed);

      rst = 1'b1;
      #2;
      chk_all("reset", 0, 0, 0, 0, 8'h00);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vq[i]) begin
         wr_en   = vq[i].wr;
         rd_en   = vq[i].rd;
         flush   = vq[i].fl;
         clr_err = vq[i].clr;
         data_in = vq[i].din;
         @(posedge clk);
         #1;
         chk_all($sformatf("v%0d", i), vq[i].cnt, vq[i].ov, vq[i].uf, vq[i].rv, vq[i].dout);
      end

      // Test 6: asynchronous reset mid-cycle during a write burst at count 3
      rd_en   = 1'b0;
      flush   = 1'b0;
      clr_err = 1'b0;
      wr_en   = 1'b1;
      data_in = 8'h77;
      #3;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 8'h00);
      @(posedge clk);
      #1;
      chk_all("held_rst", 0, 0, 0, 0, 8'h00);
      rst     = 1'b0;
      data_in = 8'h5A;
      @(posedge clk);
      #1;
      chk_all("post_rst_wr", 1, 0, 0, 0, 8'h00);
      wr_en = 1'b0;
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      chk_all("post_rst_rd", 0, 0, 0, 1, 8'h5A);
      rd_en = 1'b0;
      @(posedge clk);
      #1;
      chk("rv_pulse_end", 32'(rd_valid), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
